bcd_converter_seq: RTL and testbench

BCD_CONVERTER_SEQ -- requirements
Module: bcd_converter_seq

---
 rtl/bcd_converter_seq.sv | 106 ++++++++++
 tb/tb_bcd_converter_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_converter_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock.
// Optional two's-complement input and overflow reporting with a raw fallback result.
module bcd_converter_seq #(
  parameter int BIN_WIDTH   = 16,
  parameter int DIGITS      = 5,
  parameter int SIGNED_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  binaryCode,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   BCDcode,
  output logic                  negative,
  output logic                  overflow
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nxt;

  logic [BIN_WIDTH-1:0] sr;
  logic [BIN_WIDTH-1:0] in_mag;
  logic [BW-1:0]        dig, dig_adj, dig_nxt;
  logic [BW-1:0]        raw, in_raw;
  logic [CW-1:0]        cnt;
  logic                 ovf_trk, sign, in_neg;
  logic                 accept, last, shout, ovf_final;

  assign in_neg = (SIGNED_MODE != 0) && binaryCode[BIN_WIDTH-1];
  // Negating the most negative value wraps to 2^(BIN_WIDTH-1), which is the correct magnitude.
  assign in_mag = in_neg ? (~binaryCode + BIN_WIDTH'(1)) : binaryCode;

  generate
    if (BW <= BIN_WIDTH) begin : g_trunc
      assign in_raw = in_mag[BW-1:0];
    end else begin : g_ext
      assign in_raw = {{(BW-BIN_WIDTH){1'b0}}, in_mag};
    end
  endgenerate

  always_comb begin
    dig_adj = '0;
    for (int i = 0; i < DIGITS; i++)
      dig_adj[4*i +: 4] = (dig[4*i +: 4] >= 4'd5) ? dig[4*i +: 4] + 4'd3 : dig[4*i +: 4];
  end

  // Digits and magnitude shift as a single chain; the bit leaving the top digit signals overflow.
  assign {shout, dig_nxt} = {dig_adj, sr[BIN_WIDTH-1]};
  assign last      = (cnt == CW'(1));
  assign ovf_final = ovf_trk | shout;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE:  if (start) begin accept = 1'b1; state_nxt = SHIFT; end
      SHIFT: if (last) state_nxt = DONE;
      DONE:  begin
        if (start) begin accept = 1'b1; state_nxt = SHIFT; end
        else state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sr       <= '0;
      dig      <= '0;
      raw      <= '0;
      cnt      <= '0;
      ovf_trk  <= 1'b0;
      sign     <= 1'b0;
      BCDcode  <= '0;
      negative <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        sr      <= in_mag;
        raw     <= in_raw;
        sign    <= in_neg;
        dig     <= '0;
        ovf_trk <= 1'b0;
        cnt     <= CW'(BIN_WIDTH);
      end else if (state == SHIFT) begin
        sr      <= sr << 1;
        dig     <= dig_nxt;
        ovf_trk <= ovf_final;
        cnt     <= cnt - CW'(1);
        if (last) begin
          BCDcode  <= ovf_final ? raw : dig_nxt;
          negative <= sign;
          overflow <= ovf_final;
        end
      end
    end
  end
endmodule

// File: tb/tb_bcd_converter_seq.sv
// Directed bench for bcd_converter_seq: three configurations driven from one clock,
// expected values hand-computed per scenario.
module tb_bcd_converter_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  start;
  logic [15:0] bin0, bin1;
  logic [7:0]  bin2;
  logic [2:0]  busy, done, neg, ovf;
  logic [19:0] bcd0;
  logic [15:0] bcd1;
  logic [11:0] bcd2;

  int checks = 0;
  int failures = 0;

  bcd_converter_seq u0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .binaryCode(bin0),
    .busy(busy[0]), .done(done[0]), .BCDcode(bcd0), .negative(neg[0]), .overflow(ovf[0]));

  bcd_converter_seq #(.DIGITS(4)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .binaryCode(bin1),
    .busy(busy[1]), .done(done[1]), .BCDcode(bcd1), .negative(neg[1]), .overflow(ovf[1]));

  bcd_converter_seq #(.BIN_WIDTH(8), .DIGITS(3), .SIGNED_MODE(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .binaryCode(bin2),
    .busy(busy[2]), .done(done[2]), .BCDcode(bcd2), .negative(neg[2]), .overflow(ovf[2]));

  // One conversion on instance w; input is scrambled right after accept.
  task automatic run(input int w, input logic [15:0] val, output logic [19:0] bcd,
                     output logic o, output logic n, output int lat, output int bcnt,
                     output logic dbl);
    @(negedge clk);
    start[w] = 1'b1;
    case (w)
      0: bin0 = val;
      1: bin1 = val;
      default: bin2 = val[7:0];
    endcase
    @(posedge clk); #1;
    start[w] = 1'b0;
    bin0 = ~bin0; bin1 = ~bin1; bin2 = ~bin2;
    lat = -1; bcnt = 0; dbl = 1'b0; bcd = '0; o = 1'b0; n = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (busy[w]) bcnt++;
      if (done[w]) begin
        lat = i;
        case (w)
          0: bcd = bcd0;
          1: bcd = {4'h0, bcd1};
          default: bcd = {8'h00, bcd2};
        endcase
        o = ovf[w];
        n = neg[w];
        break;
      end
    end
    if (lat > 0) begin
      @(negedge clk);
      dbl = done[w];
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = '0; bin0 = '0; bin1 = '0; bin2 = '0;
    #12;
    checks++; if (busy !== 3'b000) begin failures++; $display("FAIL reset_busy got=%b exp=000", busy); end
    checks++; if (done !== 3'b000) begin failures++; $display("FAIL reset_done got=%b exp=000", done); end
    checks++; if ({bcd0, bcd1, bcd2} !== 48'h0) begin failures++; $display("FAIL reset_bcd got=%h exp=0", {bcd0, bcd1, bcd2}); end
    checks++; if ({neg, ovf} !== 6'b0) begin failures++; $display("FAIL reset_flags got=%b exp=000000", {neg, ovf}); end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [19:0] b; logic o, n, d; int lat, bc;
    run(0, 16'd12, b, o, n, lat, bc, d);
    checks++; if (lat !== 17) begin failures++; $display("FAIL basic_latency got=%0d exp=17", lat); end
    checks++; if (bc !== 16) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=16", bc); end
    checks++; if (b !== 20'h00012) begin failures++; $display("FAIL basic_bcd got=%h exp=00012", b); end
    checks++; if (o !== 1'b0) begin failures++; $display("FAIL basic_ovf got=%b exp=0", o); end
    checks++; if (d !== 1'b0) begin failures++; $display("FAIL basic_done_width got=%b exp=0", d); end
  endtask

  task automatic test_full_range();
    logic [19:0] b; logic o, n, d; int lat, bc;
    run(0, 16'd65535, b, o, n, lat, bc, d);
    checks++; if (b !== 20'h65535) begin failures++; $display("FAIL max_bcd got=%h exp=65535", b); end
    checks++; if (o !== 1'b0) begin failures++; $display("FAIL max_ovf got=%b exp=0", o); end
    repeat (3) @(negedge clk);
    checks++; if ({done[0], bcd0} !== {1'b0, 20'h65535}) begin failures++; $display("FAIL max_hold got=%h exp=065535", {done[0], bcd0}); end
    run(0, 16'd0, b, o, n, lat, bc, d);
    checks++; if (b !== 20'h00000) begin failures++; $display("FAIL zero_bcd got=%h exp=00000", b); end
  endtask

  task automatic test_overflow();
    logic [19:0] b; logic o, n, d; int lat, bc;
    run(1, 16'd10000, b, o, n, lat, bc, d);
    checks++; if (o !== 1'b1) begin failures++; $display("FAIL ovf_10000_flag got=%b exp=1", o); end
    checks++; if (b !== 20'h02710) begin failures++; $display("FAIL ovf_10000_raw got=%h exp=02710", b); end
    run(1, 16'd9999, b, o, n, lat, bc, d);
    checks++; if (o !== 1'b0) begin failures++; $display("FAIL ovf_9999_flag got=%b exp=0", o); end
    checks++; if (b !== 20'h09999) begin failures++; $display("FAIL ovf_9999_bcd got=%h exp=09999", b); end
  endtask

  task automatic test_signed();
    logic [19:0] b; logic o, n, d; int lat, bc;
    run(2, 16'h0080, b, o, n, lat, bc, d);
    checks++; if (lat !== 9) begin failures++; $display("FAIL signed_latency got=%0d exp=9", lat); end
    checks++; if ({n, o, b[11:0]} !== {2'b10, 12'h128}) begin failures++; $display("FAIL signed_80 got=%b/%b/%h exp=1/0/128", n, o, b[11:0]); end
    run(2, 16'h007F, b, o, n, lat, bc, d);
    checks++; if ({n, o, b[11:0]} !== {2'b00, 12'h127}) begin failures++; $display("FAIL signed_7f got=%b/%b/%h exp=0/0/127", n, o, b[11:0]); end
    run(2, 16'h00FF, b, o, n, lat, bc, d);
    checks++; if ({n, o, b[11:0]} !== {2'b10, 12'h001}) begin failures++; $display("FAIL signed_ff got=%b/%b/%h exp=1/0/001", n, o, b[11:0]); end
  endtask

  task automatic test_busy_ignored();
    int nd = 0, first = -1;
    logic [19:0] r = '0;
    @(negedge clk); start[0] = 1'b1; bin0 = 16'd12;
    @(posedge clk); #1; start[0] = 1'b0;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      if (i == 5) begin start[0] = 1'b1; bin0 = 16'd99; end
      else start[0] = 1'b0;
      if (done[0]) begin
        nd++;
        if (first < 0) begin first = i; r = bcd0; end
      end
    end
    checks++; if (nd !== 1) begin failures++; $display("FAIL ignore_done_count got=%0d exp=1", nd); end
    checks++; if (first !== 17) begin failures++; $display("FAIL ignore_latency got=%0d exp=17", first); end
    checks++; if (r !== 20'h00012) begin failures++; $display("FAIL ignore_bcd got=%h exp=00012", r); end
  endtask

  task automatic test_back_to_back();
    int t[4];
    logic [19:0] r[4];
    int nd = 0, na = 0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (done[0] && nd < 4) begin t[nd] = i; r[nd] = bcd0; nd++; end
      if (!busy[0]) begin
        if (na < 3) begin start[0] = 1'b1; bin0 = 16'(na + 1); na++; end
        else start[0] = 1'b0;
      end
    end
    start[0] = 1'b0;
    checks++; if (nd !== 3) begin failures++; $display("FAIL b2b_done_count got=%0d exp=3", nd); end
    if (nd >= 3) begin
      checks++; if (t[1] - t[0] !== 17) begin failures++; $display("FAIL b2b_gap1 got=%0d exp=17", t[1] - t[0]); end
      checks++; if (t[2] - t[1] !== 17) begin failures++; $display("FAIL b2b_gap2 got=%0d exp=17", t[2] - t[1]); end
      checks++; if ({r[0], r[1], r[2]} !== {20'h1, 20'h2, 20'h3}) begin failures++; $display("FAIL b2b_results got=%h %h %h exp=1 2 3", r[0], r[1], r[2]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [19:0] b; logic o, n, d; int lat, bc, nd;
    @(negedge clk); start[0] = 1'b1; bin0 = 16'd9999;
    @(posedge clk); #1; start[0] = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    checks++; if (busy[0] !== 1'b1) begin failures++; $display("FAIL mid_busy_before got=%b exp=1", busy[0]); end
    rst_n = 1'b0;
    #1;
    checks++; if ({busy, done} !== 6'b0) begin failures++; $display("FAIL mid_ctrl got=%b exp=000000", {busy, done}); end
    checks++; if ({bcd0, bcd1, bcd2} !== 48'h0) begin failures++; $display("FAIL mid_bcd got=%h exp=0", {bcd0, bcd1, bcd2}); end
    checks++; if ({neg, ovf} !== 6'b0) begin failures++; $display("FAIL mid_flags got=%b exp=000000", {neg, ovf}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done[0]) nd++;
    end
    checks++; if (nd !== 0) begin failures++; $display("FAIL mid_no_done got=%0d exp=0", nd); end
    run(0, 16'd42, b, o, n, lat, bc, d);
    checks++; if ({lat, b} !== {32'd17, 20'h00042}) begin failures++; $display("FAIL mid_restart got=%0d/%h exp=17/00042", lat, b); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_range();
    test_overflow();
    test_signed();
    test_busy_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
